// File: rtl/ex_operand_if.sv
// ---------------------------------------------------------------------------
// ex_operand_if
// Groups the signals of the operand stage's two handshakes.
//   Upstream (decode -> stage): in_valid/in_ready plus the decoded
//   instruction fields (cmd, rs/rt indices and values, immediate, use_imm,
//   rd_idx, wb_en).
//   Downstream (stage -> ALU): out_valid/out_ready plus alu_a, alu_b,
//   alu_cmd and the carried out_rd_idx/out_wb_en.
// The master modport is the environment: it drives decode and consumes ALU
// operands. The slave modport is the operand stage itself.
// ---------------------------------------------------------------------------
interface ex_operand_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3,
  parameter int CMD_W  = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [CMD_W-1:0]  in_cmd;
  logic [IDX_W-1:0]  in_rs_idx;
  logic [IDX_W-1:0]  in_rt_idx;
  logic [DATA_W-1:0] in_rs_val;
  logic [DATA_W-1:0] in_rt_val;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic [IDX_W-1:0]  in_rd_idx;
  logic              in_wb_en;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CMD_W-1:0]  alu_cmd;
  logic [IDX_W-1:0]  out_rd_idx;
  logic              out_wb_en;

  modport master (
    output in_valid, in_cmd, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
           in_imm, in_use_imm, in_rd_idx, in_wb_en, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_cmd, out_rd_idx, out_wb_en
  );

  modport slave (
    input  in_valid, in_cmd, in_rs_idx, in_rt_idx, in_rs_val, in_rt_val,
           in_imm, in_use_imm, in_rd_idx, in_wb_en, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_cmd, out_rd_idx, out_wb_en
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// Pipeline register in front of the 16-bit ALU. Captures decoded operands,
// resolves RAW hazards by forwarding from MEM (highest priority) and WB,
// selects register or immediate for operand B, and keeps snooping the
// forwarding buses while the held entry is stalled downstream.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   flush         drop the held entry and any entry offered this cycle
//   fwd_mem_*     MEM-stage forwarding bus (en, idx, data)
//   fwd_wb_*      WB-stage forwarding bus (en, idx, data)
//   bus (slave)   decode-side and ALU-side handshakes, see ex_operand_if
// ---------------------------------------------------------------------------
module ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3,
  parameter int CMD_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fwd_mem_en,
  input  logic [IDX_W-1:0]  fwd_mem_idx,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic              fwd_wb_en,
  input  logic [IDX_W-1:0]  fwd_wb_idx,
  input  logic [DATA_W-1:0] fwd_wb_data,
  ex_operand_if.slave       bus
);

  // Held entry. The source indices and use_imm are kept so that a stalled
  // entry can keep picking up results from producers that arrive late.
  logic              valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [IDX_W-1:0]  rd_idx_q;
  logic              wb_en_q;
  logic [IDX_W-1:0]  rs_idx_q;
  logic [IDX_W-1:0]  rt_idx_q;
  logic              use_imm_q;

  logic              capture;
  logic              hold;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic [DATA_W-1:0] hold_a;
  logic [DATA_W-1:0] hold_b;

  // r0 is never forwarded; MEM is younger than WB so it wins.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [IDX_W-1:0]  idx,
    input logic [DATA_W-1:0] dflt
  );
    if (idx != '0 && fwd_mem_en && fwd_mem_idx == idx) return fwd_mem_data;
    if (idx != '0 && fwd_wb_en && fwd_wb_idx == idx)   return fwd_wb_data;
    return dflt;
  endfunction

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !flush;
  assign hold         = valid_q && !bus.out_ready && !flush;

  always_comb begin
    // NOTE: every output of this block gets a value up front so no path
    // leaves one unassigned, which would otherwise infer a latch.
    cap_a  = fwd_sel(bus.in_rs_idx, bus.in_rs_val);
    cap_b  = bus.in_imm;
    hold_a = fwd_sel(rs_idx_q, a_q);
    hold_b = b_q;
    if (!bus.in_use_imm) cap_b  = fwd_sel(bus.in_rt_idx, bus.in_rt_val);
    if (!use_imm_q)      hold_b = fwd_sel(rt_idx_q, b_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cmd_q     <= '0;
      rd_idx_q  <= '0;
      wb_en_q   <= 1'b0;
      rs_idx_q  <= '0;
      rt_idx_q  <= '0;
      use_imm_q <= 1'b0;
    end else if (capture) begin
      // Also covers consume+capture: the new entry replaces the old one.
      valid_q   <= 1'b1;
      a_q       <= cap_a;
      b_q       <= cap_b;
      cmd_q     <= bus.in_cmd;
      rd_idx_q  <= bus.in_rd_idx;
      wb_en_q   <= bus.in_wb_en;
      rs_idx_q  <= bus.in_rs_idx;
      rt_idx_q  <= bus.in_rt_idx;
      use_imm_q <= bus.in_use_imm;
    end else begin
      if (flush || bus.out_ready) valid_q <= 1'b0;
      if (hold) begin
        a_q <= hold_a;
        b_q <= hold_b;
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_cmd    = cmd_q;
  assign bus.out_rd_idx = rd_idx_q;
  assign bus.out_wb_en  = wb_en_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level model of the operand stage.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fwd_mem_en;
  logic [2:0]  fwd_mem_idx;
  logic [15:0] fwd_mem_data;
  logic        fwd_wb_en;
  logic [2:0]  fwd_wb_idx;
  logic [15:0] fwd_wb_data;

  int n_tests = 0;
  int n_fail  = 0;

  ex_operand_if #(.DATA_W(16), .IDX_W(3), .CMD_W(3)) bus ();

  ex_operand_stage #(.DATA_W(16), .IDX_W(3), .CMD_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fwd_mem_en   (fwd_mem_en),
    .fwd_mem_idx  (fwd_mem_idx),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_en    (fwd_wb_en),
    .fwd_wb_idx   (fwd_wb_idx),
    .fwd_wb_data  (fwd_wb_data),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // Model of the entry offered to the ALU.
  typedef struct {
    bit          v;
    bit [15:0]   a, b;
    bit [2:0]    cmd, rs, rt, rd;
    bit          wb, ui;
  } entry_t;

  entry_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [15:0] resolve(input bit [2:0] idx, input bit [15:0] dflt);
    if (idx != 0 && fwd_mem_en && fwd_mem_idx == idx) return fwd_mem_data;
    if (idx != 0 && fwd_wb_en && fwd_wb_idx == idx)   return fwd_wb_data;
    return dflt;
  endfunction

  task automatic idle();
    rst = 0; flush = 0;
    bus.in_valid = 0; bus.in_cmd = 0; bus.in_rs_idx = 0; bus.in_rt_idx = 0;
    bus.in_rs_val = 0; bus.in_rt_val = 0; bus.in_imm = 0; bus.in_use_imm = 0;
    bus.in_rd_idx = 0; bus.in_wb_en = 0; bus.out_ready = 1;
    fwd_mem_en = 0; fwd_mem_idx = 0; fwd_mem_data = 0;
    fwd_wb_en = 0; fwd_wb_idx = 0; fwd_wb_data = 0;
  endtask

  task automatic offer(input bit [2:0] cmd, input bit [2:0] rs, input bit [15:0] rsv,
                       input bit [2:0] rt, input bit [15:0] rtv);
    bus.in_valid = 1; bus.in_cmd = cmd;
    bus.in_rs_idx = rs; bus.in_rs_val = rsv;
    bus.in_rt_idx = rt; bus.in_rt_val = rtv;
    bus.in_use_imm = 0; bus.in_rd_idx = 3'd1; bus.in_wb_en = 1;
  endtask

  // One clock: check outputs against the model mid-cycle, advance the model
  // with the inputs the DUT sees at the edge, then leave 1 time unit past it.
  task automatic step();
    entry_t nx;
    bit     rdy;
    @(negedge clk);
    rdy = !m.v || bus.out_ready;
    check("out_valid", bus.out_valid, m.v);
    check("in_ready", bus.in_ready, rdy);
    if (m.v) begin
      check("alu_a", bus.alu_a, m.a);
      check("alu_b", bus.alu_b, m.b);
      check("alu_cmd", bus.alu_cmd, m.cmd);
      check("out_rd_idx", bus.out_rd_idx, m.rd);
      check("out_wb_en", bus.out_wb_en, m.wb);
    end
    nx = m;
    if (rst) begin
      nx = '{default: 0};
    end else if (bus.in_valid && rdy && !flush) begin
      nx.v   = 1;
      nx.rs  = bus.in_rs_idx;
      nx.rt  = bus.in_rt_idx;
      nx.ui  = bus.in_use_imm;
      nx.cmd = bus.in_cmd;
      nx.rd  = bus.in_rd_idx;
      nx.wb  = bus.in_wb_en;
      nx.a   = resolve(bus.in_rs_idx, bus.in_rs_val);
      nx.b   = bus.in_use_imm ? bus.in_imm : resolve(bus.in_rt_idx, bus.in_rt_val);
    end else if (flush || (m.v && bus.out_ready)) begin
      nx.v = 0;
    end else if (m.v) begin
      nx.a = resolve(m.rs, m.a);
      if (!m.ui) nx.b = resolve(m.rt, m.b);
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  initial begin
    int nvalid;
    idle();

    // 1. Reset held for two edges while decode offers an instruction.
    rst = 1;
    offer(3'd5, 3'd2, 16'h1234, 3'd3, 16'h5678);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_cmd", bus.alu_cmd, 0);
    check("rst_rd_idx", bus.out_rd_idx, 0);
    check("rst_wb_en", bus.out_wb_en, 0);
    m = '{default: 0};
    idle();
    check("rst_in_ready", bus.in_ready, 1);

    // 2. Plain capture, no forwarding.
    offer(3'b000, 3'd2, 16'h0005, 3'd3, 16'h0007);
    step();
    idle();
    check("cap_valid", bus.out_valid, 1);
    check("cap_a", bus.alu_a, 16'h0005);
    check("cap_b", bus.alu_b, 16'h0007);
    check("cap_cmd", bus.alu_cmd, 0);

    // 3. MEM beats WB; r0 is never forwarded.
    offer(3'd1, 3'd4, 16'h0303, 3'd3, 16'h0007);
    fwd_mem_en = 1; fwd_mem_idx = 4; fwd_mem_data = 16'h1111;
    fwd_wb_en  = 1; fwd_wb_idx  = 4; fwd_wb_data  = 16'h2222;
    step();
    check("fwd_prio_a", bus.alu_a, 16'h1111);
    offer(3'd1, 3'd0, 16'h0000, 3'd3, 16'h0007);
    fwd_mem_en = 1; fwd_mem_idx = 0; fwd_mem_data = 16'h1111;
    fwd_wb_en  = 1; fwd_wb_idx  = 0; fwd_wb_data  = 16'h2222;
    step();
    check("fwd_r0_a", bus.alu_a, 16'h0000);
    idle();

    // 4. Immediate operand ignores a matching forward on rt.
    offer(3'd2, 3'd1, 16'h0001, 3'd5, 16'h0050);
    bus.in_use_imm = 1; bus.in_imm = 16'hFFF0;
    fwd_mem_en = 1; fwd_mem_idx = 5; fwd_mem_data = 16'hAAAA;
    step();
    check("imm_b", bus.alu_b, 16'hFFF0);
    idle();

    // 5. Stall for three cycles; WB result for r6 arrives in the second.
    offer(3'd3, 3'd6, 16'h0001, 3'd2, 16'h0009);
    step();
    idle();
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_rs_idx = 3'd7; bus.in_rs_val = 16'hDEAD;
    for (int c = 0; c < 3; c++) begin
      fwd_wb_en = (c == 1); fwd_wb_idx = 3'd6; fwd_wb_data = 16'h00FF;
      step();
      check("hold_in_ready", bus.in_ready, 0);
    end
    check("hold_a", bus.alu_a, 16'h00FF);
    idle();
    step();
    check("one_consume", bus.out_valid, 0);

    // 6. Four back-to-back instructions.
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      offer(3'(k), 3'(k + 1), 16'(k * 16 + 3), 3'(k + 2), 16'(k * 16 + 9));
      step();
      nvalid += int'(bus.out_valid);
    end
    idle();
    step();
    nvalid += int'(bus.out_valid);
    check("stream_count", nvalid, 4);

    // Flush with an instruction offered: it must never show up.
    offer(3'd7, 3'd2, 16'hBEEF, 3'd3, 16'hCAFE);
    flush = 1;
    step();
    check("flush_valid", bus.out_valid, 0);
    idle();
    step();
    check("flush_dropped", bus.out_valid, 0);

    // Reset in the middle of a stall.
    offer(3'd4, 3'd2, 16'h4444, 3'd3, 16'h5555);
    step();
    idle();
    bus.out_ready = 0;
    step();
    rst = 1;
    step();
    check("rst_mid_hold", bus.out_valid, 0);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(59) == 0);
      flush           = ($urandom_range(9) == 0);
      bus.in_valid    = ($urandom_range(3) != 0);
      bus.out_ready   = ($urandom_range(2) != 0);
      bus.in_cmd      = 3'($urandom);
      bus.in_rs_idx   = 3'($urandom);
      bus.in_rt_idx   = 3'($urandom);
      bus.in_rs_val   = (bus.in_rs_idx == 0) ? 16'h0 : 16'($urandom);
      bus.in_rt_val   = (bus.in_rt_idx == 0) ? 16'h0 : 16'($urandom);
      bus.in_imm      = 16'($urandom);
      bus.in_use_imm  = 1'($urandom);
      bus.in_rd_idx   = 3'($urandom);
      bus.in_wb_en    = 1'($urandom);
      fwd_mem_en      = 1'($urandom);
      fwd_mem_idx     = 3'($urandom);
      fwd_mem_data    = 16'($urandom);
      fwd_wb_en       = 1'($urandom);
      fwd_wb_idx      = 3'($urandom);
      fwd_wb_data     = 16'($urandom);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
